// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding, BCD digit
// width and per-digit limits, plus the digit clamp helper used on preset load.
package countdown_timer_pkg;

    // Width of one BCD digit
    localparam int DIGIT_W = 4;

    // Largest legal value of a decimal digit and of a seconds-tens digit
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX_5 = 4'd5;

    // Timer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Saturate an out-of-range BCD digit to the largest legal value
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] val,
        input logic [DIGIT_W-1:0] max_val
    );
        logic [DIGIT_W-1:0] res;
        if (val > max_val) begin
            res = max_val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit. Wraps 0 -> MAX when enabled and raises
// o_borrow in that case so the next more significant digit decrements too.
// A load has priority over the enable; loaded values above MAX are clamped.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX_9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_en,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_val,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_borrow
);

    logic [DIGIT_W-1:0] r_digit;

    // Digit register: load, decrement with wrap, or hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit <= {DIGIT_W{1'b0}};
        end else if (i_load) begin
            r_digit <= clamp_digit(i_load_val, MAX);
        end else if (i_en) begin
            if (r_digit == {DIGIT_W{1'b0}}) begin
                r_digit <= MAX;
            end else begin
                r_digit <= r_digit - {{(DIGIT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_digit <= r_digit;
        end
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_en & (r_digit == {DIGIT_W{1'b0}});

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by a 1 Hz tick enable.
// Commands: load (highest priority) > pause > start.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN -- on expiry the preset is
// reloaded and counting continues in RUN instead of stopping in DONE.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 32'd8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [7:0] ALARM_TICKS_C = ALARM_TICKS[7:0];

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_preset;
    logic        r_running;
    logic        r_done;
    logic        r_alarm;
    logic [7:0]  r_alarm_cnt;

    logic        w_dec;
    logic        w_reload;
    logic        w_done_nxt;
    logic        w_set_alarm;
    logic        w_dig_load;
    logic [15:0] w_set_clamped;
    logic [15:0] w_load_val;
    logic [15:0] w_count;
    logic        w_count_zero;
    logic        w_count_one;
    logic        w_preset_zero;
    logic [7:0]  w_alarm_cnt_inc;

    logic [DIGIT_W-1:0] w_sec_o;
    logic [DIGIT_W-1:0] w_sec_t;
    logic [DIGIT_W-1:0] w_min_o;
    logic [DIGIT_W-1:0] w_min_t;
    logic               w_borrow_so;
    logic               w_borrow_st;
    logic               w_borrow_mo;
    logic               w_unused_borrow_mt;

    // Preset digits saturated to legal BCD (seconds tens limited to 5)
    assign w_set_clamped = {clamp_digit(set_min[7:4], DIGIT_MAX_9),
                            clamp_digit(set_min[3:0], DIGIT_MAX_9),
                            clamp_digit(set_sec[7:4], DIGIT_MAX_5),
                            clamp_digit(set_sec[3:0], DIGIT_MAX_9)};

    assign w_count         = {w_min_t, w_min_o, w_sec_t, w_sec_o};
    assign w_count_zero    = (w_count == 16'h0000);
    assign w_count_one     = (w_count == 16'h0001);
    assign w_preset_zero   = (r_preset == 16'h0000);
    assign w_dig_load      = load | w_reload;
    assign w_load_val      = load ? w_set_clamped : r_preset;
    assign w_alarm_cnt_inc = r_alarm_cnt + 8'd1;

    // Four chained digits; each borrow enables the next digit up. The count
    // is only decremented while nonzero, so the top borrow never fires.
    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_sec_ones (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_dec),
        .i_load     (w_dig_load),
        .i_load_val (w_load_val[3:0]),
        .o_digit    (w_sec_o),
        .o_borrow   (w_borrow_so)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_5)) u_sec_tens (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_borrow_so),
        .i_load     (w_dig_load),
        .i_load_val (w_load_val[7:4]),
        .o_digit    (w_sec_t),
        .o_borrow   (w_borrow_st)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_min_ones (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_borrow_st),
        .i_load     (w_dig_load),
        .i_load_val (w_load_val[11:8]),
        .o_digit    (w_min_o),
        .o_borrow   (w_borrow_mo)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_min_tens (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_borrow_mo),
        .i_load     (w_dig_load),
        .i_load_val (w_load_val[15:12]),
        .o_digit    (w_min_t),
        .o_borrow   (w_unused_borrow_mt)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state, decrement/reload strobes and expiry events
    always_comb begin
        w_state_nxt = r_state;
        w_dec       = 1'b0;
        w_reload    = 1'b0;
        w_done_nxt  = 1'b0;
        w_set_alarm = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (pause) begin
                        w_state_nxt = r_state;
                    end else if (start) begin
                        if (w_count_zero) begin
                            // Starting an empty timer counts as immediate expiry
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                            w_set_alarm = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick && !w_count_zero) begin
                        w_dec = 1'b1;
                        if (w_count_one) begin
                            w_done_nxt  = 1'b1;
                            w_set_alarm = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (!w_preset_zero) begin
                                w_dec       = 1'b0;
                                w_reload    = 1'b1;
                                w_state_nxt = ST_RUN;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
`else
                            w_state_nxt = ST_DONE;
`endif
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else if (w_count_zero) begin
                        // Unreachable in normal operation; park safely
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Preset capture, kept for autoreload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_preset <= 16'h0000;
        end else if (load) begin
            r_preset <= w_set_clamped;
        end else begin
            r_preset <= r_preset;
        end
    end

    // Registered status outputs: running level and single-cycle done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= w_done_nxt;
        end
    end

    // Alarm level: set on expiry, cleared after ALARM_TICKS further ticks or load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 8'd0;
        end else if (load) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= 8'd0;
        end else if (w_set_alarm) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= 8'd0;
        end else if (r_alarm && tick) begin
            if (w_alarm_cnt_inc == ALARM_TICKS_C) begin
                r_alarm     <= 1'b0;
                r_alarm_cnt <= 8'd0;
            end else begin
                r_alarm     <= 1'b1;
                r_alarm_cnt <= w_alarm_cnt_inc;
            end
        end else begin
            r_alarm     <= r_alarm;
            r_alarm_cnt <= r_alarm_cnt;
        end
    end

    assign min_bcd = {w_min_t, w_min_o};
    assign sec_bcd = {w_sec_t, w_sec_o};
    assign running = r_running;
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer. Expected outputs are pushed to a
// scoreboard when a cycle of stimulus is driven and popped after the edge.
// Build with COUNTDOWN_AUTORELOAD_EN defined to exercise the reload variant.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       alarm;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] sc;
        logic       run;
        logic       dn;
        logic       al;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    countdown_timer #(.ALARM_TICKS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .load    (load),
        .start   (start),
        .pause   (pause),
        .set_min (set_min),
        .set_sec (set_sec),
        .min_bcd (min_bcd),
        .sec_bcd (sec_bcd),
        .running (running),
        .done    (done),
        .alarm   (alarm)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] mn, input logic [7:0] sc,
                              input logic run, input logic dn, input logic al);
        exp_t e;
        e.mn = mn; e.sc = sc; e.run = run; e.dn = dn; e.al = al;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            check_value("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check_value({t, ".min"},     32'(min_bcd), 32'(e.mn));
            check_value({t, ".sec"},     32'(sec_bcd), 32'(e.sc));
            check_value({t, ".running"}, 32'(running), 32'(e.run));
            check_value({t, ".done"},    32'(done),    32'(e.dn));
            check_value({t, ".alarm"},   32'(alarm),   32'(e.al));
        end
    endtask

    // Drive one cycle of commands, sample #1 after the rising edge
    task automatic step(input logic ld, input logic st, input logic pa, input logic tk);
        load = ld; start = st; pause = pa; tick = tk;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    endtask

    task automatic do_cycle(input string tag, input logic ld, input logic st, input logic pa,
                            input logic tk, input logic [7:0] mn, input logic [7:0] sc,
                            input logic run, input logic dn, input logic al);
        expect_out(tag, mn, sc, run, dn, al);
        step(ld, st, pa, tk);
        compare_out();
    endtask

    task automatic check_state(input string tag, input state_e exp_st);
        check_value(tag, 32'(dut.r_state), 32'(exp_st));
    endtask

    // Reference one-second decrement through plain integer arithmetic
    function automatic logic [15:0] dec_model(input logic [15:0] mmss);
        int m;
        int s;
        int t;
        logic [15:0] r;
        m = int'(mmss[15:12]) * 10 + int'(mmss[11:8]);
        s = int'(mmss[7:4]) * 10 + int'(mmss[3:0]);
        t = m * 60 + s;
        if (t > 0) t = t - 1;
        m = t / 60;
        s = t % 60;
        r[15:12] = 4'(m / 10);
        r[11:8]  = 4'(m % 10);
        r[7:4]   = 4'(s / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    initial begin
        logic [15:0] cur;
        reset_n = 1'b0;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        set_min = 8'h00; set_sec = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        compare_out();
        check_state("reset.state", ST_IDLE);
        reset_n = 1'b1;

        // 01:00 -> start -> one tick -> 00:59
        set_min = 8'h01; set_sec = 8'h00;
        do_cycle("ld0100",  1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle("st0100",  1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        do_cycle("tk0100",  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Expiry reloads the preset and keeps running
        set_min = 8'h00; set_sec = 8'h01;
        do_cycle("ar_ld",   1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
        do_cycle("ar_st",   1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        do_cycle("ar_exp",  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
        check_state("ar_exp.state", ST_RUN);
        do_cycle("ar_post", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
        do_cycle("ar_exp2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
`else
        // 00:02 expiry, done pulse, alarm for 8 ticks, DONE ignores start/pause
        set_min = 8'h00; set_sec = 8'h02;
        do_cycle("ld0002",  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
        do_cycle("st0002",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        do_cycle("tk1",     1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        do_cycle("expire",  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check_state("expire.state", ST_DONE);
        do_cycle("postexp", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        do_cycle("done_st", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state("done_st.state", ST_DONE);
        for (int i = 1; i <= 7; i++) begin
            do_cycle("alarm_on", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        do_cycle("alarm_off", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("alarm_off.state", ST_DONE);
`endif

        // Pause wins over a simultaneous tick, then resume
        set_min = 8'h10; set_sec = 8'h00;
        do_cycle("ld1000",  1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle("st1000",  1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
        do_cycle("pa_tk",   1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("pa_tk.state", ST_PAUSE);
        do_cycle("pa_idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle("resume",  1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
        do_cycle("tk1000",  1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);

        // Invalid BCD preset is clamped
        set_min = 8'h7F; set_sec = 8'hAB;
        do_cycle("clamp",   1'b1, 1'b0, 1'b0, 1'b0, 8'h79, 8'h59, 1'b0, 1'b0, 1'b0);

        // Load beats start/pause in the same cycle; tick ignored in IDLE
        set_min = 8'h03; set_sec = 8'h00;
        do_cycle("ld_pri",  1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("ld_pri.state", ST_IDLE);
        do_cycle("idle_tk", 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);

        // Borrow chain against the integer model, crossing a minute boundary
        set_min = 8'h02; set_sec = 8'h05;
        cur = 16'h0205;
        do_cycle("ld0205",  1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h05, 1'b0, 1'b0, 1'b0);
        do_cycle("st0205",  1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h05, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 66; i++) begin
            cur = dec_model(cur);
            do_cycle("chain", 1'b0, 1'b0, 1'b0, 1'b1, cur[15:8], cur[7:0], 1'b1, 1'b0, 1'b0);
        end

        // Start on 00:00 expires immediately
        set_min = 8'h00; set_sec = 8'h00;
        do_cycle("ld0000",  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        do_cycle("st0000",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check_state("st0000.state", ST_DONE);

        // Asynchronous reset between edges while running at 05:30
        set_min = 8'h05; set_sec = 8'h30;
        do_cycle("ld0530",  1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h30, 1'b0, 1'b0, 1'b0);
        do_cycle("st0530",  1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h30, 1'b1, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        compare_out();
        check_state("async_rst.state", ST_IDLE);
        #1;
        reset_n = 1'b1;
        do_cycle("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("post_rst.state", ST_IDLE);

        check_value("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
